// File: rtl/sd_pkg.sv
// Shared types and constants for the SPI-mode SD command engine.
// SD_CRC7_EN selects a computed CRC-7 instead of the fixed init-sequence CRC byte.
package sd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        RESP,
        TAIL,
        DONE
    } state_t;

    localparam int         FRAME_W  = 48;
    localparam logic [7:0] CRC_CMD0 = 8'h95;
    localparam logic [7:0] CRC_CMD8 = 8'h87;
    localparam logic [7:0] CRC_NONE = 8'h01;
    localparam logic [7:0] R1_NONE  = 8'hFF;

    // Precomputed {crc7,1} for the only commands that need it before CRC is disabled.
    function automatic logic [7:0] fixed_crc(input logic [5:0] idx);
        logic [7:0] b;
        unique case (1'b1)
            idx == 6'd0: b = CRC_CMD0;
            idx == 6'd8: b = CRC_CMD8;
            default:     b = CRC_NONE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Combinational CRC-7 (x^7+x^3+1, init 0) over the first 40 command frame bits.
// Only instantiated when SD_CRC7_EN is defined.
module sd_crc7 (
    input  logic [39:0] data_i,
    output logic [6:0]  crc_o
);

    logic [6:0] c;
    logic       fb;

    always_comb begin
        c  = '0;
        fb = 1'b0;
        for (int i = 39; i >= 0; i--) begin
            fb = data_i[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) begin
                c = c ^ 7'h09;
            end
        end
        crc_o = c;
    end

endmodule

// File: rtl/sd_cmd_sender.sv
// SPI-mode SD command engine: frames and sends a 48-bit command, polls for R1.
// Define SD_CRC7_EN to compute CRC-7 at latch time instead of the fixed table.
module sd_cmd_sender #(
    parameter int DIV      = 2,
    parameter int RESP_MAX = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [5:0]  cmd,
    input  logic [31:0] arg,
    output logic        busy,
    output logic        done,
    output logic [7:0]  r1,
    output logic        timeout,
    output logic        spi_cs,
    output logic        spi_sclk,
    input  logic        spi_miso,
    output logic        spi_mosi
);

    import sd_pkg::*;

    localparam int            DW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [7:0]    POLL_LAST = 8'(RESP_MAX - 1);

    state_t             state_q;
    logic [DW-1:0]      div_q;
    logic [5:0]         bit_q;
    logic [7:0]         poll_q;
    logic [FRAME_W-1:0] frame_q;
    logic [7:0]         rx_q;
    logic               cs_q;
    logic               sclk_q;
    logic               busy_q;
    logic               done_q;
    logic [7:0]         r1_q;
    logic               timeout_q;

    logic [7:0]         crc_d;
    logic [FRAME_W-1:0] frame_d;
    logic               tick;

`ifdef SD_CRC7_EN
    logic [6:0] crc7;

    sd_crc7 u_crc7 (
        .data_i ({2'b01, cmd, arg}),
        .crc_o  (crc7)
    );

    assign crc_d = {crc7, 1'b1};
`else
    assign crc_d = fixed_crc(cmd);
`endif

    assign frame_d = {2'b01, cmd, arg, crc_d};
    assign tick    = (div_q == DIV_LAST);

    // Frame shifts in ones, so MOSI naturally idles high once the command is out.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            poll_q    <= '0;
            frame_q   <= '1;
            rx_q      <= R1_NONE;
            cs_q      <= 1'b1;
            sclk_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            r1_q      <= R1_NONE;
            timeout_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        frame_q   <= frame_d;
                        r1_q      <= R1_NONE;
                        timeout_q <= 1'b0;
                        busy_q    <= 1'b1;
                        cs_q      <= 1'b0;
                        div_q     <= '0;
                        bit_q     <= '0;
                        poll_q    <= '0;
                        state_q   <= CMD;
                    end
                end
                CMD, RESP, TAIL: begin
                    div_q <= tick ? '0 : div_q + 1'b1;
                    if (tick && !sclk_q) begin
                        sclk_q <= 1'b1;
                        if (state_q != TAIL) begin
                            rx_q <= {rx_q[6:0], spi_miso};
                        end
                    end else if (tick) begin
                        sclk_q <= 1'b0;
                        bit_q  <= bit_q + 6'd1;
                        if (state_q == CMD) begin
                            frame_q <= {frame_q[FRAME_W-2:0], 1'b1};
                            if (bit_q == 6'(FRAME_W - 1)) begin
                                bit_q   <= '0;
                                state_q <= RESP;
                            end
                        end else if (state_q == RESP) begin
                            if (bit_q == 6'd7) begin
                                bit_q  <= '0;
                                poll_q <= poll_q + 8'd1;
                                if (!rx_q[7]) begin
                                    r1_q    <= rx_q;
                                    state_q <= TAIL;
                                end else if (poll_q == POLL_LAST) begin
                                    r1_q      <= R1_NONE;
                                    timeout_q <= 1'b1;
                                    state_q   <= TAIL;
                                end
                            end
                        end else if (bit_q == 6'd7) begin
                            bit_q   <= '0;
                            cs_q    <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign r1       = r1_q;
    assign timeout  = timeout_q;
    assign spi_cs   = cs_q;
    assign spi_sclk = sclk_q;
    assign spi_mosi = frame_q[FRAME_W-1];

endmodule

// File: tb/tb_sd_cmd_sender.sv
// Scoreboard bench for sd_cmd_sender with an SD card BFM on the SPI pins.
// Works in both builds; SD_CRC7_EN switches the expected CRC byte.
module tb_sd_cmd_sender;

    localparam int DIV      = 2;
    localparam int RESP_MAX = 8;

    logic        clock    = 1'b0;
    logic        reset_n  = 1'b0;
    logic        start    = 1'b0;
    logic [5:0]  cmd      = '0;
    logic [31:0] arg      = '0;
    logic        spi_miso = 1'b1;
    logic        busy, done, timeout, spi_cs, spi_sclk, spi_mosi;
    logic [7:0]  r1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [47:0] frame;
        logic [7:0]  r1;
        logic        to;
        int          rises;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always #5 clock = ~clock;

    sd_cmd_sender #(.DIV(DIV), .RESP_MAX(RESP_MAX)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .cmd      (cmd),
        .arg      (arg),
        .busy     (busy),
        .done     (done),
        .r1       (r1),
        .timeout  (timeout),
        .spi_cs   (spi_cs),
        .spi_sclk (spi_sclk),
        .spi_miso (spi_miso),
        .spi_mosi (spi_mosi)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // CRC byte as polynomial long division of msg*x^7 by x^7+x^3+1.
    function automatic logic [7:0] exp_crc(input logic [5:0] c,
                                           input logic [31:0] a);
`ifdef SD_CRC7_EN
        logic [46:0] m;
        m = {2'b01, c, a, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (m[i]) m[i -: 8] = m[i -: 8] ^ 8'h89;
        end
        return {m[6:0], 1'b1};
`else
        if (c == 6'd0) return 8'h95;
        if (c == 6'd8) return 8'h87;
        return 8'h01;
`endif
    endfunction

    function automatic logic [47:0] model_frame(input logic [5:0] c,
                                                input logic [31:0] a);
        return {2'b01, c, a, exp_crc(c, a)};
    endfunction

    // Card BFM: captures MOSI on SCLK rises, serves response bytes on MISO.
    int          bfm_d      = 0;
    logic [7:0]  bfm_r1     = 8'h01;
    bit          bfm_silent = 1'b0;
    logic        cap[$];
    int          n_rise     = 0;
    logic        b_pcs      = 1'b1;
    logic        b_psclk    = 1'b0;

    function automatic logic resp_bit(input int k);
        logic [7:0] v;
        int         b;
        if (k < 48) return 1'b1;
        b = (k - 48) / 8;
        v = (!bfm_silent && b == bfm_d) ? bfm_r1 : 8'hFF;
        return v[7 - ((k - 48) % 8)];
    endfunction

    initial forever begin
        @(negedge clock);
        if (spi_cs) begin
            spi_miso = 1'b1;
        end else begin
            if (b_pcs) begin
                cap.delete();
                n_rise   = 0;
                spi_miso = resp_bit(0);
            end
            if (spi_sclk && !b_psclk) begin
                cap.push_back(spi_mosi);
                n_rise++;
                spi_miso = resp_bit(n_rise);
            end
        end
        b_pcs   = spi_cs;
        b_psclk = spi_sclk;
    end

    // Pin protocol: CS only while busy, idle levels, half-period of DIV clocks.
    int   hi_n = 0;
    int   lo_n = 0;
    logic p_sclk = 1'b0;

    initial forever begin
        @(negedge clock);
        if (reset_n) begin
            if (!spi_cs && !busy) chk("cs_while_idle", 1, 0);
            if (spi_cs && (spi_sclk || !spi_mosi))
                chk("idle_pins", {spi_sclk, spi_mosi}, 2'b01);
            if (spi_cs) begin
                hi_n = 0;
                lo_n = 0;
            end else if (spi_sclk && !p_sclk) begin
                chk("sclk_low_len", lo_n, DIV);
                lo_n = 0;
                hi_n = 1;
            end else if (spi_sclk) begin
                hi_n++;
            end else if (p_sclk) begin
                chk("sclk_high_len", hi_n, DIV);
                hi_n = 0;
                lo_n = 1;
            end else begin
                lo_n++;
            end
        end
        p_sclk = spi_sclk;
    end

    // Monitor: pops the scoreboard on every done pulse.
    int bcnt = 0;

    initial forever begin
        exp_t        e;
        logic [47:0] f;
        logic        ones;
        @(negedge clock);
        if (!reset_n) begin
            bcnt = 0;
        end else begin
            bcnt = busy ? bcnt + 1 : 0;
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    f = '0;
                    for (int i = 0; i < 48 && i < cap.size(); i++)
                        f = {f[46:0], cap[i]};
                    ones = 1'b1;
                    for (int i = 48; i < cap.size(); i++)
                        if (cap[i] !== 1'b1) ones = 1'b0;
                    chk("frame", f, e.frame);
                    chk("r1", r1, e.r1);
                    chk("timeout", timeout, e.to);
                    chk("sclk_count", cap.size(), e.rises);
                    chk("resp_mosi_high", ones, 1);
                    chk("latency", bcnt, e.lat);
                end
            end
        end
    end

    task automatic run_txn(input logic [47:0] fr, input int d,
                           input logic [7:0] rv, input bit silent,
                           input bit glitch, input bit at_done);
        exp_t e;
        int   polls;
        bit   ok;
        bfm_d      = d;
        bfm_r1     = rv;
        bfm_silent = silent;
        if (!silent && d < RESP_MAX) begin
            polls = d + 1;
            e.r1  = rv;
            e.to  = 1'b0;
        end else begin
            polls = RESP_MAX;
            e.r1  = 8'hFF;
            e.to  = 1'b1;
        end
        e.frame = fr;
        e.rises = 48 + 8 * polls + 8;
        e.lat   = 2 * DIV * e.rises + 1;
        sb.push_back(e);
        @(negedge clock);
        start = 1'b1;
        cmd   = fr[45:40];
        arg   = fr[39:8];
        @(negedge clock);
        start = 1'b0;
        cmd   = 6'($urandom);
        arg   = $urandom;
        chk("accept", {busy, timeout}, 2'b10);
        ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clock);
            start = glitch && (i == 37);
            if (done) ok = 1'b1;
        end
        start = 1'b0;
        if (!ok) begin
            chk("done_wait", 0, 1);
            sb.delete();
            return;
        end
        if (at_done) begin
            start = 1'b1;
            cmd   = 6'($urandom);
            arg   = $urandom;
        end
        @(negedge clock);
        start = 1'b0;
        chk("done_pulse", {done, busy}, 2'b00);
        repeat (2) @(negedge clock);
        chk("held", {busy, r1, timeout}, {1'b0, e.r1, e.to});
    endtask

    task automatic reset_mid_cmd();
        bit ok;
        bfm_silent = 1'b0;
        bfm_d      = 0;
        bfm_r1     = 8'h01;
        @(negedge clock);
        start = 1'b1;
        cmd   = 6'd17;
        arg   = $urandom;
        @(negedge clock);
        start = 1'b0;
        ok    = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clock);
            if (!spi_cs && n_rise == 20) ok = 1'b1;
        end
        if (!ok) chk("reset_reach_bit20", 0, 1);
        #2 reset_n = 1'b0;
        #1 chk("reset_async", {spi_cs, spi_sclk, spi_mosi, busy, done, r1, timeout},
               {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0});
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  c;
        logic [31:0] a;
        int          d;
        #12;
        chk("reset_state", {spi_cs, spi_sclk, spi_mosi, busy, done, r1, timeout},
            {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0});
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        run_txn(48'h40_0000_0000_95, 1, 8'h01, 1'b0, 1'b0, 1'b0);
        run_txn(48'h48_0000_01AA_87, 0, 8'h01, 1'b0, 1'b0, 1'b0);
`ifdef SD_CRC7_EN
        run_txn(48'h77_0000_0000_65, 2, 8'h00, 1'b0, 1'b0, 1'b0);
`else
        run_txn(48'h77_0000_0000_01, 2, 8'h00, 1'b0, 1'b0, 1'b0);
`endif
        run_txn(model_frame(6'd17, 32'h1234_5678), 0, 8'h05, 1'b1, 1'b0, 1'b0);
        run_txn(model_frame(6'd16, 32'h0000_0200), RESP_MAX - 1, 8'h7E,
                1'b0, 1'b0, 1'b0);
        run_txn(model_frame(6'd24, 32'hDEAD_BEEF), RESP_MAX, 8'h00,
                1'b0, 1'b0, 1'b0);
        run_txn(model_frame(6'd41, 32'h4000_0000), 3, 8'h01, 1'b0, 1'b1, 1'b1);

        reset_mid_cmd();
        run_txn(48'h40_0000_0000_95, 0, 8'h01, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            c = 6'($urandom);
            a = $urandom;
            d = $urandom_range(0, RESP_MAX + 1);
            run_txn(model_frame(c, a), d, 8'($urandom_range(0, 127)),
                    ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1);
        end

        repeat (4) @(negedge clock);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
